pixel24_rx_sink: RTL and testbench
==================================

Name: pixel24_rx_sink

Overview:
- Receive end of the 24-bit pixel link driven by the sub1 pixel producer.
- Accepts pixels over a valid/ready handshake and buffers them in a small FIFO.
- Re-derives line and frame position from a start-of-frame marker and presents the pixels downstream with eol/eof framing.
- Detects framing errors: a start-of-frame marker that arrives while a frame is still in progress.

Parameters:
DEPTH, 4, FIFO entries; power of 2, at least 2
LINE_WIDTH, 8, pixels per line; at least 2
FRAME_LINES, 4, lines per frame; at least 1

Ports:
cp  input  1  clock; all state changes on the rising edge
reset  input  1  asynchronous, active-low reset
in_pixel  input  24  incoming pixel, {R[23:16], G[15:8], B[7:0]}
in_sof  input  1  marks in_pixel as the first pixel of a frame
in_valid  input  1  in_pixel and in_sof are valid
in_ready  output  1  sink can accept a pixel
out_pixel  output  24  buffered pixel
out_valid  output  1  out_pixel is valid
out_ready  input  1  downstream accepts out_pixel
out_sof  output  1  out_pixel is column 0, row 0
out_eol  output  1  out_pixel is the last pixel of its line
out_eof  output  1  out_pixel is the last pixel of the frame
col  output  $clog2(LINE_WIDTH)  column of out_pixel
row  output  $clog2(FRAME_LINES)  row of out_pixel
level  output  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH
err_sync  output  1  sticky framing-error flag
err_clr  input  1  clears err_sync

Behaviour:
- Reset (reset low, asynchronous):
  - FIFO empty, read/write pointers 0, level 0.
  - col 0, row 0, err_sync 0.
  - in_ready 1; out_valid, out_sof, out_eol and out_eof all 0; out_pixel 0.
- Push:
  - in_ready = (level != DEPTH).
  - On a cp edge with in_valid & in_ready, {in_sof, in_pixel} is written at the write pointer, which then increments modulo DEPTH.
  - in_pixel is ignored while in_valid is low.
- Pop:
  - out_valid = (level != 0).
  - out_pixel and the stored sof are read combinationally from the entry at the read pointer.
  - On a cp edge with out_valid & out_ready, the read pointer increments modulo DEPTH.
- Latency:
  - A pixel pushed into an empty FIFO at edge N drives out_valid from just after edge N.
  - With out_ready held high, that pixel is popped at edge N+1.
  - Sustained throughput is 1 pixel per cycle.
- Level:
  - +1 on push only; -1 on pop only; unchanged on simultaneous push and pop.
  - When full, in_ready is 0, so no push can occur even if a pop happens in the same cycle (no full-throughput bypass).
- Position tracking (advances only on a pop):
  - If the popped entry has sof = 1 and (col, row) != (0, 0): err_sync is set, and col/row resynchronise so that this pixel is treated as (0, 0); the next position is then col 1, row 0 (or col 0, row 1 if LINE_WIDTH were 1).
  - Otherwise col increments; when col = LINE_WIDTH-1 it wraps to 0 and row increments.
  - When row = FRAME_LINES-1 and the line ends, row wraps to 0.
- Output framing, combinational from the current position and head entry, qualified by out_valid:
  - out_sof = head sof flag.
  - out_eol = (col == LINE_WIDTH-1).
  - out_eof = out_eol & (row == FRAME_LINES-1).
  - During an error resync, col/row/out_eol/out_eof reflect the resynchronised position (0, 0).
- A frame with no sof marker is accepted; the counters simply keep wrapping. sof is required only to establish alignment.
- err_sync:
  - Sets on a detected violation; holds until err_clr.
  - A set event in the same cycle as err_clr wins, so err_sync stays 1.
- Reset asserted mid-transfer discards all buffered pixels and the position immediately; no partial pop is reported.

Test Plan:
- Reset, then push 3 pixels with out_ready=0 (0x111111 with sof=1, 0x222222, 0x333333) -> level=3, in_ready=1, out_pixel=0x111111, out_sof=1, col=0, row=0.
- Hold out_ready=0 and push until full -> level=4, in_ready=0; a 5th in_valid pulse is not accepted. Pop one with in_valid held -> the next cycle accepts, level returns to 4.
- Stream one frame of 32 pixels (sof on the first only) with in_valid and out_ready held at 1 -> out_eol on pixels 7/15/23/31, out_eof only on pixel 31, err_sync=0, col and row both 0 after the frame.
- Apply sof on the 5th pixel of a line -> err_sync=1 when that pixel pops; it shows col=0, row=0, out_sof=1; the following pixel shows col=1. Assert err_clr -> err_sync=0.
- Assert err_clr in the same cycle as a new sync violation -> err_sync remains 1.
- Drop reset mid-stream with level=2 -> level=0, out_valid=0, in_ready=1, col=0, row=0 immediately, without waiting for a cp edge.

Source files
------------

// File: rtl/pixel24_rx_sink.sv
// Receive end of the 24-bit pixel link. It buffers incoming pixels in a small
// FIFO, rebuilds the line/frame position from the sof markers, and presents
// the pixels downstream with sof/eol/eof framing. An sof that arrives while a
// frame is still in progress sets the sticky err_sync flag and realigns the
// position to (0, 0) at that pixel.
module pixel24_rx_sink #(
  parameter int DEPTH       = 4,
  parameter int LINE_WIDTH  = 8,
  parameter int FRAME_LINES = 4,
  localparam int PW  = $clog2(DEPTH),
  localparam int LVW = $clog2(DEPTH) + 1,
  localparam int CW  = $clog2(LINE_WIDTH),
  localparam int RW  = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1
) (
  input  logic           cp,
  input  logic           reset,
  input  logic [23:0]    in_pixel,
  input  logic           in_sof,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [23:0]    out_pixel,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_sof,
  output logic           out_eol,
  output logic           out_eof,
  output logic [CW-1:0]  col,
  output logic [RW-1:0]  row,
  output logic [LVW-1:0] level,
  output logic           err_sync,
  input  logic           err_clr
);

  localparam logic [CW-1:0]  COL_LAST = CW'(LINE_WIDTH - 1);
  localparam logic [RW-1:0]  ROW_LAST = RW'(FRAME_LINES - 1);
  localparam logic [LVW-1:0] LVL_FULL = LVW'(DEPTH);

  // Each entry holds {sof, pixel}.
  logic [24:0]    r_mem [DEPTH];
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [LVW-1:0] r_level;
  logic [CW-1:0]  r_col;
  logic [RW-1:0]  r_row;
  logic           r_err_sync;

  logic           w_push;
  logic           w_pop;
  logic           w_valid;
  logic [24:0]    w_head;
  logic           w_head_sof;
  logic           w_resync;
  logic [CW-1:0]  w_col;
  logic [RW-1:0]  w_row;
  logic           w_eol;
  logic [CW-1:0]  w_col_nxt;
  logic [RW-1:0]  w_row_nxt;

  assign in_ready   = (r_level != LVL_FULL);
  assign w_valid    = (r_level != '0);
  assign w_push     = in_valid & in_ready;
  assign w_pop      = w_valid & out_ready;
  assign w_head     = r_mem[r_rd_ptr];
  assign w_head_sof = w_valid & w_head[24];

  // An sof away from (0, 0) is a framing error; that pixel is shown at (0, 0).
  assign w_resync = w_head_sof & ((r_col != '0) | (r_row != '0));
  assign w_col    = w_resync ? '0 : r_col;
  assign w_row    = w_resync ? '0 : r_row;
  assign w_eol    = (w_col == COL_LAST);

  // Position after the head pixel, starting from the (possibly realigned) one.
  always_comb begin
    w_col_nxt = w_col + CW'(1);
    w_row_nxt = w_row;
    if (w_eol) begin
      w_col_nxt = '0;
      w_row_nxt = (w_row == ROW_LAST) ? '0 : w_row + RW'(1);
    end
  end

  // Storage array; contents need no reset since out_pixel is gated by out_valid.
  always_ff @(posedge cp) begin
    if (w_push) r_mem[r_wr_ptr] <= {in_sof, in_pixel};
  end

  // FIFO pointers and occupancy; pointers wrap naturally as DEPTH is a power of 2.
  always_ff @(posedge cp or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_level <= r_level + LVW'(1);
      else if (w_pop && !w_push) r_level <= r_level - LVW'(1);
    end
  end

  // Line/frame position advances only when a pixel leaves.
  always_ff @(posedge cp or negedge reset) begin
    if (!reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_pop) begin
      r_col <= w_col_nxt;
      r_row <= w_row_nxt;
    end
  end

  // Sticky framing error; a new violation beats a simultaneous clear.
  always_ff @(posedge cp or negedge reset) begin
    if (!reset)                r_err_sync <= 1'b0;
    else if (w_pop && w_resync) r_err_sync <= 1'b1;
    else if (err_clr)          r_err_sync <= 1'b0;
  end

  assign out_valid = w_valid;
  assign out_pixel = w_valid ? w_head[23:0] : 24'h0;
  assign out_sof   = w_head_sof;
  assign out_eol   = w_valid & w_eol;
  assign out_eof   = w_valid & w_eol & (w_row == ROW_LAST);
  assign col       = w_col;
  assign row       = w_row;
  assign level     = r_level;
  assign err_sync  = r_err_sync;

endmodule

// File: tb/tb_pixel24_rx_sink.sv
// Directed bench for pixel24_rx_sink with default parameters
// (DEPTH 4, LINE_WIDTH 8, FRAME_LINES 4).
module tb_pixel24_rx_sink;

  logic        cp;
  logic        reset;
  logic [23:0] in_pixel;
  logic        in_sof;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] out_pixel;
  logic        out_valid;
  logic        out_ready;
  logic        out_sof;
  logic        out_eol;
  logic        out_eof;
  logic [2:0]  col;
  logic [1:0]  row;
  logic [2:0]  level;
  logic        err_sync;
  logic        err_clr;

  int n_pass;
  int n_chk;

  pixel24_rx_sink dut (
    .cp        (cp),
    .reset     (reset),
    .in_pixel  (in_pixel),
    .in_sof    (in_sof),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_pixel (out_pixel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sof   (out_sof),
    .out_eol   (out_eol),
    .out_eof   (out_eof),
    .col       (col),
    .row       (row),
    .level     (level),
    .err_sync  (err_sync),
    .err_clr   (err_clr)
  );

  initial cp = 1'b0;
  always #5 cp = ~cp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge cp);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    n_pass    = 0;
    n_chk     = 0;
    reset     = 1'b0;
    in_pixel  = '0;
    in_sof    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    #2;
    check("rst_level",     32'(level),     32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_pixel", 32'(out_pixel), 32'd0);
    check("rst_eol_eof",   32'({out_sof, out_eol, out_eof}), 32'd0);
    check("rst_col_row",   32'({col, row}), 32'd0);
    check("rst_err",       32'(err_sync),  32'd0);
    tick();
    reset = 1'b1;
    tick();

    // Three pushes with the sink stalled.
    in_valid = 1'b1; in_sof = 1'b1; in_pixel = 24'h111111; tick();
    in_sof = 1'b0;   in_pixel = 24'h222222; tick();
    in_pixel = 24'h333333; tick();
    in_valid = 1'b0;
    check("p3_level",    32'(level),     32'd3);
    check("p3_in_ready", 32'(in_ready),  32'd1);
    check("p3_pixel",    32'(out_pixel), 32'h111111);
    check("p3_sof",      32'(out_sof),   32'd1);
    check("p3_col_row",  32'({col, row}), 32'd0);

    // Fill, then an attempted push while full.
    in_valid = 1'b1; in_pixel = 24'h444444; tick();
    check("full_level", 32'(level),    32'd4);
    check("full_ready", 32'(in_ready), 32'd0);
    in_pixel = 24'h555555; tick();
    check("full_noacc", 32'(level),    32'd4);
    // Pop while full with in_valid held: no push that cycle.
    out_ready = 1'b1; tick();
    check("pop_full_level", 32'(level),    32'd3);
    check("pop_full_ready", 32'(in_ready), 32'd1);
    check("pop_full_col",   32'(col),      32'd1);
    out_ready = 1'b0; tick();
    in_valid = 1'b0;
    check("refill_level", 32'(level),     32'd4);
    check("refill_head",  32'(out_pixel), 32'h222222);

    // Full frame streamed at one pixel per cycle from an aligned start.
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 32; k++) begin
      in_valid = 1'b1; in_sof = (k == 0); in_pixel = 24'(k + 24'hA00000);
      tick();
      check("frm_pixel", 32'(out_pixel), 32'(k + 24'hA00000));
      check("frm_eol",   32'(out_eol),   32'((k % 8) == 7));
      check("frm_eof",   32'(out_eof),   32'(k == 31));
    end
    in_valid = 1'b0; in_sof = 1'b0;
    tick();
    check("frm_end_level", 32'(level),    32'd0);
    check("frm_end_err",   32'(err_sync), 32'd0);
    check("frm_end_col",   32'(col),      32'd0);
    check("frm_end_row",   32'(row),      32'd0);

    // sof on the fifth pixel of a line.
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1; in_sof = (k == 0) || (k == 4); in_pixel = 24'(k + 24'hB00000);
      tick();
      if (k == 4) begin
        check("sync_head_col", 32'(col),      32'd0);
        check("sync_head_row", 32'(row),      32'd0);
        check("sync_head_sof", 32'(out_sof),  32'd1);
        check("sync_pre_err",  32'(err_sync), 32'd0);
      end
      if (k == 5) begin
        check("sync_err",      32'(err_sync), 32'd1);
        check("sync_next_col", 32'(col),      32'd1);
        check("sync_next_row", 32'(row),      32'd0);
        check("sync_next_sof", 32'(out_sof),  32'd0);
      end
    end
    in_valid = 1'b0; in_sof = 1'b0;
    tick();
    check("sync_drain_col", 32'(col), 32'd2);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("sync_clr", 32'(err_sync), 32'd0);

    // Clear in the same cycle as a new violation: set wins.
    out_ready = 1'b0;
    in_valid = 1'b1; in_sof = 1'b1; in_pixel = 24'hC0FFEE; tick();
    in_valid = 1'b0; in_sof = 1'b0;
    check("race_head_col", 32'(col), 32'd0);
    out_ready = 1'b1; err_clr = 1'b1; tick();
    err_clr = 1'b0;
    check("race_err", 32'(err_sync), 32'd1);
    check("race_col", 32'(col),      32'd1);

    // Asynchronous reset with two pixels buffered.
    out_ready = 1'b0;
    in_valid = 1'b1; in_pixel = 24'h0A0A0A; tick();
    in_pixel = 24'h0B0B0B; tick();
    in_valid = 1'b0;
    check("pre_rst_level", 32'(level), 32'd2);
    #2;
    reset = 1'b0;
    #1;
    check("arst_level",     32'(level),     32'd0);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready",  32'(in_ready),  32'd1);
    check("arst_col_row",   32'({col, row}), 32'd0);
    check("arst_err",       32'(err_sync),  32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
